// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq
// Brief    : Multi-domain reset sequencer; lock-filtered ordered release,
//            reverse-order shutdown on software request.
// Revision : 1.0
// ============================================================================
module rst_seq #(
    parameter int N_DOMAINS = 3,
    parameter int LOCK_FILT = 4,
    parameter int REL_DLY   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 lock_i,
    input  logic                 sw_rst_i,
    output logic [N_DOMAINS-1:0] rst_o,
    output logic                 ready_o,
    output logic [1:0]           state_o
);

    localparam int CNT_MAX = (LOCK_FILT > REL_DLY) ? LOCK_FILT : REL_DLY;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(N_DOMAINS + 1);

    localparam logic [1:0] S_HOLD     = 2'd0;
    localparam logic [1:0] S_RELEASE  = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;
    localparam logic [1:0] S_SHUTDOWN = 2'd3;

    localparam logic [CW-1:0]        FILT_LAST = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0]        DLY_LAST  = CW'(REL_DLY - 1);
    localparam logic [IW-1:0]        K_LAST    = IW'(N_DOMAINS - 1);
    localparam logic [IW-1:0]        K_SHUT    = IW'((N_DOMAINS > 1) ? (N_DOMAINS - 2) : 0);
    localparam logic [N_DOMAINS-1:0] ALL_ON    = {N_DOMAINS{1'b1}};
    localparam logic [N_DOMAINS-1:0] TOP_BIT   = ALL_ON ^ (ALL_ON >> 1);

    logic [1:0]    state;
    logic [CW-1:0] filt_cnt;
    logic [CW-1:0] dly_cnt;
    logic [IW-1:0] k;
    logic          lk_meta;
    logic          lk_s;

    assign state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_HOLD;
            rst_o    <= ALL_ON;
            ready_o  <= 1'b0;
            filt_cnt <= '0;
            dly_cnt  <= '0;
            k        <= '0;
            lk_meta  <= 1'b0;
            lk_s     <= 1'b0;
        end else begin
            lk_meta <= lock_i;
            lk_s    <= lk_meta;

            case (state)
                S_HOLD: begin
                    rst_o   <= ALL_ON;
                    ready_o <= 1'b0;
                    if (lk_s) begin
                        if (filt_cnt == FILT_LAST) begin
                            state    <= S_RELEASE;
                            filt_cnt <= '0;
                            dly_cnt  <= '0;
                            k        <= '0;
                        end else begin
                            filt_cnt <= filt_cnt + 1'b1;
                        end
                    end else begin
                        filt_cnt <= '0;
                    end
                end

                S_RELEASE: begin
                    if (!lk_s) begin
                        state    <= S_HOLD;
                        rst_o    <= ALL_ON;
                        ready_o  <= 1'b0;
                        filt_cnt <= '0;
                        dly_cnt  <= '0;
                        k        <= '0;
                    end else if (dly_cnt == DLY_LAST) begin
                        // Shifting the thermometer left releases the lowest asserted domain
                        dly_cnt <= '0;
                        rst_o   <= rst_o << 1;
                        k       <= k + 1'b1;
                        if (k == K_LAST) begin
                            state   <= S_RUN;
                            ready_o <= 1'b1;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    if (!lk_s) begin
                        state    <= S_HOLD;
                        rst_o    <= ALL_ON;
                        ready_o  <= 1'b0;
                        filt_cnt <= '0;
                        dly_cnt  <= '0;
                        k        <= '0;
                    end else if (sw_rst_i) begin
                        ready_o <= 1'b0;
                        rst_o   <= TOP_BIT;
                        k       <= K_SHUT;
                        dly_cnt <= '0;
                        if (N_DOMAINS == 1) begin
                            state    <= S_HOLD;
                            filt_cnt <= '0;
                        end else begin
                            state <= S_SHUTDOWN;
                        end
                    end
                end

                S_SHUTDOWN: begin
                    if (!lk_s) begin
                        state    <= S_HOLD;
                        rst_o    <= ALL_ON;
                        ready_o  <= 1'b0;
                        filt_cnt <= '0;
                        dly_cnt  <= '0;
                        k        <= '0;
                    end else if (dly_cnt == DLY_LAST) begin
                        dly_cnt <= '0;
                        rst_o   <= (rst_o >> 1) | TOP_BIT;
                        if (k == '0) begin
                            state    <= S_HOLD;
                            filt_cnt <= '0;
                        end else begin
                            k <= k - 1'b1;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= S_HOLD;
                    rst_o    <= ALL_ON;
                    ready_o  <= 1'b0;
                    filt_cnt <= '0;
                    dly_cnt  <= '0;
                    k        <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq
// Brief    : Scoreboard bench for rst_seq with default parameters.
// Revision : 1.0
// ============================================================================
module tb_rst_seq;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       lock_i;
    logic       sw_rst_i;
    logic [2:0] rst_o;
    logic       ready_o;
    logic [1:0] state_o;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       rdy;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];

    rst_seq #(
        .N_DOMAINS(3),
        .LOCK_FILT(4),
        .REL_DLY  (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .lock_i  (lock_i),
        .sw_rst_i(sw_rst_i),
        .rst_o   (rst_o),
        .ready_o (ready_o),
        .state_o (state_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void push(int c, logic [2:0] r, logic rd, logic [1:0] s);
        exp_t e;
        e.cyc = c; e.rst = r; e.rdy = rd; e.st = s;
        sb.push_back(e);
    endfunction

    task automatic test_reset;
        rst_ni   = 1'b0;
        lock_i   = 1'b1;
        sw_rst_i = 1'b1;
        repeat (4) @(negedge clk_i);
        vectors++;
        if ({rst_o, ready_o, state_o} !== {3'b111, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL reset: rst_o=%b ready_o=%b state_o=%0d, expected 111 0 0", rst_o, ready_o, state_o);
        end
        sw_rst_i = 1'b0;
    endtask

    task automatic test_power_up;
        exp_t e;
        int   base;
        base   = cyc;
        rst_ni = 1'b1;
        lock_i = 1'b1;
        push(base+5,  3'b111, 1'b0, 2'd0);
        push(base+6,  3'b111, 1'b0, 2'd1);
        push(base+21, 3'b111, 1'b0, 2'd1);
        push(base+22, 3'b110, 1'b0, 2'd1);
        push(base+37, 3'b110, 1'b0, 2'd1);
        push(base+38, 3'b100, 1'b0, 2'd1);
        push(base+53, 3'b100, 1'b0, 2'd1);
        push(base+54, 3'b000, 1'b1, 2'd2);
        for (int i = 1; i <= 56; i++) begin
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); vectors++;
                if ({rst_o, ready_o, state_o} !== {e.rst, e.rdy, e.st}) begin
                    miscompares++;
                    $display("FAIL power_up edge %0d (due %0d): rst_o=%b ready_o=%b state_o=%0d, expected %b %b %0d",
                             cyc, e.cyc, rst_o, ready_o, state_o, e.rst, e.rdy, e.st);
                end
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_lock_glitch;
        exp_t e;
        int   base;
        lock_i = 1'b0;
        rst_ni = 1'b0; #1 rst_ni = 1'b1;
        base = cyc;
        push(base+6,  3'b111, 1'b0, 2'd0);
        push(base+9,  3'b111, 1'b0, 2'd0);
        push(base+10, 3'b111, 1'b0, 2'd1);
        push(base+25, 3'b111, 1'b0, 2'd1);
        push(base+26, 3'b110, 1'b0, 2'd1);
        push(base+57, 3'b100, 1'b0, 2'd1);
        push(base+58, 3'b000, 1'b1, 2'd2);
        for (int i = 1; i <= 60; i++) begin
            if (i == 1) lock_i = 1'b1;
            if (i == 4) lock_i = 1'b0;
            if (i == 5) lock_i = 1'b1;
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); vectors++;
                if ({rst_o, ready_o, state_o} !== {e.rst, e.rdy, e.st}) begin
                    miscompares++;
                    $display("FAIL lock_glitch edge %0d (due %0d): rst_o=%b ready_o=%b state_o=%0d, expected %b %b %0d",
                             cyc, e.cyc, rst_o, ready_o, state_o, e.rst, e.rdy, e.st);
                end
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_sw_reset;
        exp_t e;
        int   base;
        base = cyc;
        push(base+1,  3'b100, 1'b0, 2'd3);
        push(base+16, 3'b100, 1'b0, 2'd3);
        push(base+17, 3'b110, 1'b0, 2'd3);
        push(base+32, 3'b110, 1'b0, 2'd3);
        push(base+33, 3'b111, 1'b0, 2'd0);
        push(base+36, 3'b111, 1'b0, 2'd0);
        push(base+37, 3'b111, 1'b0, 2'd1);
        push(base+53, 3'b110, 1'b0, 2'd1);
        push(base+69, 3'b100, 1'b0, 2'd1);
        push(base+84, 3'b100, 1'b0, 2'd1);
        push(base+85, 3'b000, 1'b1, 2'd2);
        for (int i = 1; i <= 87; i++) begin
            if (i == 1) sw_rst_i = 1'b1;
            if (i == 2) sw_rst_i = 1'b0;
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); vectors++;
                if ({rst_o, ready_o, state_o} !== {e.rst, e.rdy, e.st}) begin
                    miscompares++;
                    $display("FAIL sw_reset edge %0d (due %0d): rst_o=%b ready_o=%b state_o=%0d, expected %b %b %0d",
                             cyc, e.cyc, rst_o, ready_o, state_o, e.rst, e.rdy, e.st);
                end
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_lock_loss_release;
        exp_t e;
        int   base;
        rst_ni = 1'b0; #1 rst_ni = 1'b1;
        base = cyc;
        push(base+22,  3'b110, 1'b0, 2'd1);
        push(base+24,  3'b110, 1'b0, 2'd1);
        push(base+25,  3'b111, 1'b0, 2'd0);
        push(base+40,  3'b111, 1'b0, 2'd0);
        push(base+60,  3'b111, 1'b0, 2'd0);
        push(base+65,  3'b111, 1'b0, 2'd0);
        push(base+66,  3'b111, 1'b0, 2'd1);
        push(base+113, 3'b100, 1'b0, 2'd1);
        push(base+114, 3'b000, 1'b1, 2'd2);
        for (int i = 1; i <= 116; i++) begin
            if (i == 23) lock_i = 1'b0;
            if (i == 61) lock_i = 1'b1;
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); vectors++;
                if ({rst_o, ready_o, state_o} !== {e.rst, e.rdy, e.st}) begin
                    miscompares++;
                    $display("FAIL lock_loss edge %0d (due %0d): rst_o=%b ready_o=%b state_o=%0d, expected %b %b %0d",
                             cyc, e.cyc, rst_o, ready_o, state_o, e.rst, e.rdy, e.st);
                end
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_simultaneous;
        exp_t e;
        int   base;
        base = cyc;
        push(base+2,  3'b000, 1'b1, 2'd2);
        push(base+3,  3'b111, 1'b0, 2'd0);
        push(base+4,  3'b111, 1'b0, 2'd0);
        push(base+9,  3'b111, 1'b0, 2'd0);
        push(base+10, 3'b111, 1'b0, 2'd1);
        push(base+26, 3'b110, 1'b0, 2'd1);
        push(base+58, 3'b000, 1'b1, 2'd2);
        for (int i = 1; i <= 60; i++) begin
            if (i == 1) lock_i   = 1'b0;
            if (i == 3) sw_rst_i = 1'b1;
            if (i == 4) sw_rst_i = 1'b0;
            if (i == 5) lock_i   = 1'b1;
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); vectors++;
                if ({rst_o, ready_o, state_o} !== {e.rst, e.rdy, e.st}) begin
                    miscompares++;
                    $display("FAIL simultaneous edge %0d (due %0d): rst_o=%b ready_o=%b state_o=%0d, expected %b %b %0d",
                             cyc, e.cyc, rst_o, ready_o, state_o, e.rst, e.rdy, e.st);
                end
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        int   base;
        base = cyc;
        push(base+1,  3'b100, 1'b0, 2'd3);
        push(base+9,  3'b100, 1'b0, 2'd3);
        push(base+14, 3'b111, 1'b0, 2'd0);
        push(base+15, 3'b111, 1'b0, 2'd1);
        push(base+31, 3'b110, 1'b0, 2'd1);
        push(base+47, 3'b100, 1'b0, 2'd1);
        push(base+63, 3'b000, 1'b1, 2'd2);
        for (int i = 1; i <= 65; i++) begin
            if (i == 1) sw_rst_i = 1'b1;
            if (i == 2) sw_rst_i = 1'b0;
            if (i == 10) begin
                rst_ni = 1'b0;
                #1;
                vectors++;
                if ({rst_o, ready_o, state_o} !== {3'b111, 1'b0, 2'd0}) begin
                    miscompares++;
                    $display("FAIL async_reset immediate: rst_o=%b ready_o=%b state_o=%0d, expected 111 0 0",
                             rst_o, ready_o, state_o);
                end
                #1 rst_ni = 1'b1;
            end
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); vectors++;
                if ({rst_o, ready_o, state_o} !== {e.rst, e.rdy, e.st}) begin
                    miscompares++;
                    $display("FAIL async_reset edge %0d (due %0d): rst_o=%b ready_o=%b state_o=%0d, expected %b %b %0d",
                             cyc, e.cyc, rst_o, ready_o, state_o, e.rst, e.rdy, e.st);
                end
            end
            @(negedge clk_i);
        end
    endtask

    initial begin
        test_reset;
        test_power_up;
        test_lock_glitch;
        test_sw_reset;
        test_lock_loss_release;
        test_simultaneous;
        test_async_reset;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
